hazard_stall_controller: RTL and testbench
==========================================

Name: hazard_stall_controller

Overview:
- Central pipeline sequencer for the 5-stage core.
- Drives the write-enable and bubble controls of the PC, IF/ID and ID/EX latches: `disableIDEXWrite` and `nop` map directly onto the decode/execute latch.
- Detects RAW hazards against in-flight writers, applies squash on taken branches/jumps, freezes on data-memory stalls and drains the pipe on HALT.
- Contains one small FSM plus down-counters; all outputs are derived from state and current-cycle inputs.

Parameters:
- FORWARDING, 0: 1 = EX/MEM forwarding exists, so only load-use stalls; 0 = stall on any EX/MEM writer match.
- DRAIN_CYCLES, 3: cycles from HALT leaving decode to HALT retiring in WB.
- REDIRECT_SQUASH, 2: bubbles inserted after a taken redirect (IF/ID plus the following fetch slot).

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous reset, active-low
- readReg1Sel_d  in  3  decode source register 1
- readReg1Used_d  in  1  source 1 is actually read
- readReg2Sel_d  in  3  decode source register 2
- readReg2Used_d  in  1  source 2 is actually read
- halt_d  in  1  HALT instruction in decode
- writeRegSel_e  in  4  EX destination; 4'b1111 = invalid/bubble
- regWrite_e  in  1  EX instruction writes the register file
- memRead_e  in  1  EX instruction is a load
- writeRegSel_m  in  4  MEM destination; 4'b1111 = invalid
- regWrite_m  in  1  MEM instruction writes the register file
- redirect_e  in  1  taken branch or jump resolved in EX
- memStall  in  1  data memory busy; whole pipe must freeze
- disablePCWrite  out  1  hold PC
- disableIFIDWrite  out  1  hold IF/ID latch
- disableIDEXWrite  out  1  hold ID/EX latch
- nop  out  1  load a bubble into ID/EX
- flushIFID  out  1  load a bubble into IF/ID
- halted  out  1  pipeline drained after HALT; sticky until reset

Behaviour:
- Reset (rst=0, async): state=RUN, counters=0, halted=0. All disable/nop/flush outputs are 0 while in reset.
- States: RUN, SQUASH, DRAIN, HALTED (2-bit encoding).
- match1 = readReg1Used_d & ({1'b0,readReg1Sel_d}==W) for W in {writeRegSel_e, writeRegSel_m}; match2 defined the same way for source 2.
- A destination of 4'b1111 never matches (3-bit selects are zero-extended, so it cannot).
- raw, FORWARDING=0: (match vs E & regWrite_e) | (match vs M & regWrite_m).
- raw, FORWARDING=1: match vs E & regWrite_e & memRead_e.
- Priority per cycle, highest first: memStall > redirect_e > raw > halt_d.
- memStall=1 (any state except HALTED): disablePCWrite=disableIFIDWrite=disableIDEXWrite=1, nop=flush=0. State and counters hold.
- redirect_e=1 in RUN/SQUASH/DRAIN:
  - Same cycle: flushIFID=1, nop=1, PC write enabled (new target loads).
  - Next state SQUASH with sq_cnt=REDIRECT_SQUASH-1.
  - An in-progress DRAIN is cancelled, because the HALT was on the wrong path.
- SQUASH: flushIFID=1 and nop=1 each cycle; sq_cnt decrements; at 0, return to RUN. A new redirect reloads the count.
- raw in RUN: disablePCWrite=disableIFIDWrite=1, nop=1, disableIDEXWrite=0. Re-evaluated every cycle; no state change.
- halt_d in RUN with no higher event:
  - nop=0 so the HALT itself passes; PC and IF/ID are disabled.
  - Next state DRAIN with dr_cnt=DRAIN_CYCLES-1.
- DRAIN: PC and IF/ID held, nop=1; dr_cnt decrements; at 0, go to HALTED.
- HALTED: halted=1; all disables=1; nop=1; memStall and redirect_e are ignored. Exit only by reset.
- Counters are 2 bits wide and never wrap, because reloads happen only on entry.
- Reset mid-SQUASH or mid-DRAIN returns to RUN immediately.

Optional Feature:
- Macro HAZARD_STALL_STATS_EN.
- When defined: adds 16-bit outputs stallCount and squashCount.
  - stallCount increments on each raw-stall cycle.
  - squashCount increments on each cycle with flushIFID=1.
  - Both saturate at 16'hFFFF, reset to 0, and hold during memStall and HALTED.
- When not defined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - state typedef/localparams ST_RUN, ST_SQUASH, ST_DRAIN, ST_HALTED;
  - REG_INVALID = 4'b1111;
  - NOP_INSTR = 16'h0800.
- Natural sub-module: hazard_compare. Purely combinational; computes raw from the select/valid inputs and FORWARDING. Reused by the future forwarding unit.

Test Plan:
- ADD to R3 in EX (writeRegSel_e=3, regWrite_e=1), decode reads R3, FORWARDING=0 -> nop=1 and PC/IF/ID held for 2 cycles (EX then MEM), released when writeRegSel_m becomes 4'b1111.
- Load to R5 in EX, decode reads R5, FORWARDING=1 -> exactly 1 stall cycle; non-load ALU writer to R5 -> 0 stall cycles.
- redirect_e pulse at cycle 10 -> flushIFID=nop=1 at cycles 10, 11 and 12; RUN at 13. Second redirect at 11 -> squash extends through 13.
- halt_d at cycle 20 -> DRAIN for cycles 21-23, halted=1 from 24; a redirect at 22 cancels the drain (halted stays 0).
- memStall held during raw and during SQUASH -> all three disables=1, sq_cnt frozen, resumes the exact remaining count after release.
- rst pulled low in DRAIN (async, mid-cycle) -> outputs 0 immediately, halted=0, RUN after rst=1.

Source files
------------

// File: rtl/hazard_stall_controller_pkg.sv
// Shared types and constants for the pipeline hazard/stall sequencer.
// Contents: sequencer state encoding, the "no destination" register code and
// the bubble instruction word. Imported by the controller and hazard_compare.
package hazard_stall_controller_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SQUASH = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  // Destination code carried by bubbles and non-writing instructions.
  localparam logic [3:0] REG_INVALID = 4'b1111;

  // Encoding of the bubble the latches load when nop/flush is asserted.
  localparam logic [15:0] NOP_INSTR = 16'h0800;

endpackage

// File: rtl/hazard_stall_controller_if.sv
// Bundle of decode/execute/memory hazard inputs and latch-control outputs of
// hazard_stall_controller.
//   master : pipeline side (drives hazard inputs, receives controls)
//   slave  : the controller
// Optional build macro HAZARD_STALL_STATS_EN adds stallCount/squashCount.
interface hazard_stall_controller_if;

  logic [2:0]  readReg1Sel_d;
  logic        readReg1Used_d;
  logic [2:0]  readReg2Sel_d;
  logic        readReg2Used_d;
  logic        halt_d;
  logic [3:0]  writeRegSel_e;
  logic        regWrite_e;
  logic        memRead_e;
  logic [3:0]  writeRegSel_m;
  logic        regWrite_m;
  logic        redirect_e;
  logic        memStall;

  logic        disablePCWrite;
  logic        disableIFIDWrite;
  logic        disableIDEXWrite;
  logic        nop;
  logic        flushIFID;
  logic        halted;
`ifdef HAZARD_STALL_STATS_EN
  logic [15:0] stallCount;
  logic [15:0] squashCount;
`endif

  modport master (
`ifdef HAZARD_STALL_STATS_EN
    input  stallCount,
    input  squashCount,
`endif
    output readReg1Sel_d,
    output readReg1Used_d,
    output readReg2Sel_d,
    output readReg2Used_d,
    output halt_d,
    output writeRegSel_e,
    output regWrite_e,
    output memRead_e,
    output writeRegSel_m,
    output regWrite_m,
    output redirect_e,
    output memStall,
    input  disablePCWrite,
    input  disableIFIDWrite,
    input  disableIDEXWrite,
    input  nop,
    input  flushIFID,
    input  halted
  );

  modport slave (
`ifdef HAZARD_STALL_STATS_EN
    output stallCount,
    output squashCount,
`endif
    input  readReg1Sel_d,
    input  readReg1Used_d,
    input  readReg2Sel_d,
    input  readReg2Used_d,
    input  halt_d,
    input  writeRegSel_e,
    input  regWrite_e,
    input  memRead_e,
    input  writeRegSel_m,
    input  regWrite_m,
    input  redirect_e,
    input  memStall,
    output disablePCWrite,
    output disableIFIDWrite,
    output disableIDEXWrite,
    output nop,
    output flushIFID,
    output halted
  );

endinterface

// File: rtl/hazard_compare.sv
// Combinational RAW hazard detector: compares the decode source selects
// against the EX and MEM destinations.
//   FORWARDING=0 : any EX or MEM register writer match stalls.
//   FORWARDING=1 : only a load in EX matching a source stalls (load-use).
// Ports: read_reg{1,2}_{sel,used}_i, write_reg_sel_{e,m}_i, reg_write_{e,m}_i,
//        mem_read_e_i, raw_o.
module hazard_compare
  import hazard_stall_controller_pkg::*;
#(
  parameter int unsigned FORWARDING = 0
) (
  input  logic [2:0] read_reg1_sel_i,
  input  logic       read_reg1_used_i,
  input  logic [2:0] read_reg2_sel_i,
  input  logic       read_reg2_used_i,
  input  logic [3:0] write_reg_sel_e_i,
  input  logic       reg_write_e_i,
  input  logic       mem_read_e_i,
  input  logic [3:0] write_reg_sel_m_i,
  input  logic       reg_write_m_i,
  output logic       raw_o
);

  logic fwd;
  logic valid_e, valid_m;
  logic match_e, match_m;
  logic stall_e, stall_m;

  assign fwd = (FORWARDING != 0);

  // Zero-extended 3-bit selects can never equal REG_INVALID; the explicit
  // check keeps that guarantee if the select width ever grows.
  assign valid_e = (write_reg_sel_e_i != REG_INVALID);
  assign valid_m = (write_reg_sel_m_i != REG_INVALID);

  always_comb begin
    match_e = valid_e &
              ((read_reg1_used_i & ({1'b0, read_reg1_sel_i} == write_reg_sel_e_i)) |
               (read_reg2_used_i & ({1'b0, read_reg2_sel_i} == write_reg_sel_e_i)));
    match_m = valid_m &
              ((read_reg1_used_i & ({1'b0, read_reg1_sel_i} == write_reg_sel_m_i)) |
               (read_reg2_used_i & ({1'b0, read_reg2_sel_i} == write_reg_sel_m_i)));
    // With forwarding only a load in EX cannot be bypassed; MEM always can.
    stall_e = match_e & reg_write_e_i & (mem_read_e_i | ~fwd);
    stall_m = match_m & reg_write_m_i & ~fwd;
    raw_o   = stall_e | stall_m;
  end

endmodule

// File: rtl/hazard_stall_controller.sv
// Central pipeline sequencer for the 5-stage core. Drives the PC, IF/ID and
// ID/EX latch write-enables and bubble controls: stalls on RAW hazards,
// squashes after taken redirects, freezes on data-memory stalls and drains
// the pipe on HALT.
// Ports: clk, rst (async, active-low), bus (hazard_stall_controller_if.slave).
// Parameters: FORWARDING, DRAIN_CYCLES, REDIRECT_SQUASH.
// Optional build macro HAZARD_STALL_STATS_EN adds saturating 16-bit
// stallCount / squashCount outputs.
module hazard_stall_controller
  import hazard_stall_controller_pkg::*;
#(
  parameter int unsigned FORWARDING      = 0,
  parameter int unsigned DRAIN_CYCLES    = 3,
  parameter int unsigned REDIRECT_SQUASH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  hazard_stall_controller_if.slave  bus
);

  // Counters hold "remaining cycles after this one", so load N-1 on entry.
  localparam logic [1:0] SqReload = 2'(REDIRECT_SQUASH - 1);
  localparam logic [1:0] DrReload = 2'(DRAIN_CYCLES - 1);

  state_e     state_q, state_d;
  logic [1:0] sq_cnt_q, sq_cnt_d;
  logic [1:0] dr_cnt_q, dr_cnt_d;

  logic raw;
  logic raw_stall;
  logic dis_pc, dis_ifid, dis_idex, nop_int, flush_int;

  hazard_compare #(
    .FORWARDING (FORWARDING)
  ) u_hazard_compare (
    .read_reg1_sel_i   (bus.readReg1Sel_d),
    .read_reg1_used_i  (bus.readReg1Used_d),
    .read_reg2_sel_i   (bus.readReg2Sel_d),
    .read_reg2_used_i  (bus.readReg2Used_d),
    .write_reg_sel_e_i (bus.writeRegSel_e),
    .reg_write_e_i     (bus.regWrite_e),
    .mem_read_e_i      (bus.memRead_e),
    .write_reg_sel_m_i (bus.writeRegSel_m),
    .reg_write_m_i     (bus.regWrite_m),
    .raw_o             (raw)
  );

  always_comb begin
    state_d   = state_q;
    sq_cnt_d  = sq_cnt_q;
    dr_cnt_d  = dr_cnt_q;
    dis_pc    = 1'b0;
    dis_ifid  = 1'b0;
    dis_idex  = 1'b0;
    nop_int   = 1'b0;
    flush_int = 1'b0;
    raw_stall = 1'b0;

    if (state_q == ST_HALTED) begin
      // Terminal: ignores memStall and redirects, only reset leaves.
      dis_pc   = 1'b1;
      dis_ifid = 1'b1;
      dis_idex = 1'b1;
      nop_int  = 1'b1;
    end else if (bus.memStall) begin
      dis_pc   = 1'b1;
      dis_ifid = 1'b1;
      dis_idex = 1'b1;
    end else if (bus.redirect_e) begin
      // PC stays writable so the redirect target loads this cycle. Any drain
      // in progress belonged to a wrong-path HALT and is abandoned.
      flush_int = 1'b1;
      nop_int   = 1'b1;
      state_d   = ST_SQUASH;
      sq_cnt_d  = SqReload;
      dr_cnt_d  = 2'd0;
    end else begin
      unique case (state_q)
        ST_SQUASH: begin
          flush_int = 1'b1;
          nop_int   = 1'b1;
          if (sq_cnt_q == 2'd0) begin
            state_d = ST_RUN;
          end else begin
            sq_cnt_d = sq_cnt_q - 2'd1;
          end
        end
        ST_DRAIN: begin
          dis_pc   = 1'b1;
          dis_ifid = 1'b1;
          nop_int  = 1'b1;
          if (dr_cnt_q == 2'd0) begin
            state_d = ST_HALTED;
          end else begin
            dr_cnt_d = dr_cnt_q - 2'd1;
          end
        end
        ST_RUN: begin
          if (raw) begin
            dis_pc    = 1'b1;
            dis_ifid  = 1'b1;
            nop_int   = 1'b1;
            raw_stall = 1'b1;
          end else if (bus.halt_d) begin
            // HALT itself proceeds into ID/EX; fetch is frozen behind it.
            dis_pc   = 1'b1;
            dis_ifid = 1'b1;
            state_d  = ST_DRAIN;
            dr_cnt_d = DrReload;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_RUN;
      sq_cnt_q <= 2'd0;
      dr_cnt_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      sq_cnt_q <= sq_cnt_d;
      dr_cnt_q <= dr_cnt_d;
    end
  end

  // Controls are forced low for the whole time reset is held.
  assign bus.disablePCWrite   = rst & dis_pc;
  assign bus.disableIFIDWrite = rst & dis_ifid;
  assign bus.disableIDEXWrite = rst & dis_idex;
  assign bus.nop              = rst & nop_int;
  assign bus.flushIFID        = rst & flush_int;
  assign bus.halted           = rst & (state_q == ST_HALTED);

`ifdef HAZARD_STALL_STATS_EN
  logic [15:0] stall_count_q, stall_count_d;
  logic [15:0] squash_count_q, squash_count_d;

  // raw_stall and flush_int are already low during memStall and HALTED.
  always_comb begin
    stall_count_d  = stall_count_q;
    squash_count_d = squash_count_q;
    if (raw_stall && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
    if (flush_int && (squash_count_q != 16'hFFFF)) begin
      squash_count_d = squash_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count_q  <= 16'd0;
      squash_count_q <= 16'd0;
    end else begin
      stall_count_q  <= stall_count_d;
      squash_count_q <= squash_count_d;
    end
  end

  assign bus.stallCount  = stall_count_q;
  assign bus.squashCount = squash_count_q;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Randomised bench for hazard_stall_controller. Two instances share one
// stimulus stream (FORWARDING=0 and FORWARDING=1); each is compared every
// cycle against a cycle-count reference model that tracks outstanding squash
// and drain bubbles plus a sticky halted flag. Mid-cycle async resets are
// injected at random.
module tb_hazard_stall_controller;

  localparam int RS = 2;
  localparam int DC = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0] sel1, sel2;
  logic       used1, used2, halt, rw_e, mr_e, rw_m, redir, mstall;
  logic [3:0] we, wm;

  hazard_stall_controller_if bus0 ();
  hazard_stall_controller_if bus1 ();

  assign bus0.readReg1Sel_d  = sel1;
  assign bus0.readReg1Used_d = used1;
  assign bus0.readReg2Sel_d  = sel2;
  assign bus0.readReg2Used_d = used2;
  assign bus0.halt_d         = halt;
  assign bus0.writeRegSel_e  = we;
  assign bus0.regWrite_e     = rw_e;
  assign bus0.memRead_e      = mr_e;
  assign bus0.writeRegSel_m  = wm;
  assign bus0.regWrite_m     = rw_m;
  assign bus0.redirect_e     = redir;
  assign bus0.memStall       = mstall;

  assign bus1.readReg1Sel_d  = sel1;
  assign bus1.readReg1Used_d = used1;
  assign bus1.readReg2Sel_d  = sel2;
  assign bus1.readReg2Used_d = used2;
  assign bus1.halt_d         = halt;
  assign bus1.writeRegSel_e  = we;
  assign bus1.regWrite_e     = rw_e;
  assign bus1.memRead_e      = mr_e;
  assign bus1.writeRegSel_m  = wm;
  assign bus1.regWrite_m     = rw_m;
  assign bus1.redirect_e     = redir;
  assign bus1.memStall       = mstall;

  hazard_stall_controller #(
    .FORWARDING      (0),
    .DRAIN_CYCLES    (DC),
    .REDIRECT_SQUASH (RS)
  ) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  hazard_stall_controller #(
    .FORWARDING      (1),
    .DRAIN_CYCLES    (DC),
    .REDIRECT_SQUASH (RS)
  ) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  // {disablePCWrite, disableIFIDWrite, disableIDEXWrite, nop, flushIFID, halted}
  logic [5:0] obs [2];
  assign obs[0] = {bus0.disablePCWrite, bus0.disableIFIDWrite, bus0.disableIDEXWrite,
                   bus0.nop, bus0.flushIFID, bus0.halted};
  assign obs[1] = {bus1.disablePCWrite, bus1.disableIFIDWrite, bus1.disableIDEXWrite,
                   bus1.nop, bus1.flushIFID, bus1.halted};

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: bubbles still owed and the sticky halt.
  int   sq_left [2];
  int   dr_left [2];
  bit   hlt     [2];
  int   nx_sq   [2];
  int   nx_dr   [2];
  bit   nx_hlt  [2];
  logic [5:0] exp_o [2];
`ifdef HAZARD_STALL_STATS_EN
  int stc [2];
  int sqc [2];
  int nx_stc [2];
  int nx_sqc [2];
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit model_raw(input bit fwd);
    bit src_e, src_m;
    src_e = (used1 && (int'(sel1) == int'(we))) || (used2 && (int'(sel2) == int'(we)));
    src_m = (used1 && (int'(sel1) == int'(wm))) || (used2 && (int'(sel2) == int'(wm)));
    if (fwd) return src_e && rw_e && mr_e;
    return (src_e && rw_e) || (src_m && rw_m);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      sq_left[d] = 0;
      dr_left[d] = 0;
      hlt[d]     = 1'b0;
`ifdef HAZARD_STALL_STATS_EN
      stc[d] = 0;
      sqc[d] = 0;
`endif
    end
  endtask

  task automatic model_eval(input int d);
    bit r;
    r         = model_raw(d == 1);
    nx_sq[d]  = sq_left[d];
    nx_dr[d]  = dr_left[d];
    nx_hlt[d] = hlt[d];
`ifdef HAZARD_STALL_STATS_EN
    nx_stc[d] = stc[d];
    nx_sqc[d] = sqc[d];
`endif
    if (hlt[d]) begin
      exp_o[d] = 6'b111101;
    end else if (mstall) begin
      exp_o[d] = 6'b111000;
    end else if (redir) begin
      exp_o[d] = 6'b000110;
      nx_sq[d] = RS;
      nx_dr[d] = 0;
    end else if (sq_left[d] > 0) begin
      exp_o[d] = 6'b000110;
      nx_sq[d] = sq_left[d] - 1;
    end else if (dr_left[d] > 0) begin
      exp_o[d] = 6'b110100;
      nx_dr[d] = dr_left[d] - 1;
      if (dr_left[d] == 1) nx_hlt[d] = 1'b1;
    end else if (r) begin
      exp_o[d] = 6'b110100;
`ifdef HAZARD_STALL_STATS_EN
      if (stc[d] < 65535) nx_stc[d] = stc[d] + 1;
`endif
    end else if (halt) begin
      exp_o[d] = 6'b110000;
      nx_dr[d] = DC;
    end else begin
      exp_o[d] = 6'b000000;
    end
`ifdef HAZARD_STALL_STATS_EN
    if (exp_o[d][1] && (sqc[d] < 65535)) nx_sqc[d] = sqc[d] + 1;
`endif
  endtask

  task automatic model_commit();
    for (int d = 0; d < 2; d++) begin
      sq_left[d] = nx_sq[d];
      dr_left[d] = nx_dr[d];
      hlt[d]     = nx_hlt[d];
`ifdef HAZARD_STALL_STATS_EN
      stc[d] = nx_stc[d];
      sqc[d] = nx_sqc[d];
`endif
    end
  endtask

  task automatic quiet_inputs();
    sel1 = 3'd0; sel2 = 3'd0; used1 = 1'b0; used2 = 1'b0; halt = 1'b0;
    we = 4'hF; wm = 4'hF; rw_e = 1'b0; mr_e = 1'b0; rw_m = 1'b0;
    redir = 1'b0; mstall = 1'b0;
  endtask

  task automatic random_inputs();
    mstall = ($urandom_range(0, 7) == 0);
    redir  = ($urandom_range(0, 15) == 0);
    halt   = ($urandom_range(0, 39) == 0);
    we     = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 7));
    wm     = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 7));
    sel1   = ($urandom_range(0, 1) == 1) ? we[2:0] : 3'($urandom_range(0, 7));
    sel2   = ($urandom_range(0, 1) == 1) ? wm[2:0] : 3'($urandom_range(0, 7));
    used1  = 1'($urandom_range(0, 1));
    used2  = 1'($urandom_range(0, 1));
    rw_e   = 1'($urandom_range(0, 1));
    mr_e   = 1'($urandom_range(0, 1));
    rw_m   = 1'($urandom_range(0, 1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_o0"}, 32'(obs[0]), 32'd0);
    check({tag, "_o1"}, 32'(obs[1]), 32'd0);
`ifdef HAZARD_STALL_STATS_EN
    check({tag, "_stall0"}, 32'(bus0.stallCount), 32'd0);
    check({tag, "_squash0"}, 32'(bus0.squashCount), 32'd0);
`endif
  endtask

  initial begin
    quiet_inputs();
    model_reset();
    #1 rst = 1'b0;
    #2;
    check_reset_outputs("reset");
    // Load-use hazard present while reset is held must still be masked.
    sel1 = 3'd5; used1 = 1'b1; we = 4'd5; rw_e = 1'b1; mr_e = 1'b1; halt = 1'b1;
    #1;
    check_reset_outputs("reset_inputs");
    quiet_inputs();
    @(negedge clk);
    rst = 1'b1;

    for (int c = 0; c < 4000; c++) begin
      cyc = c;
      @(negedge clk);
      random_inputs();
      #1;
      for (int d = 0; d < 2; d++) begin
        model_eval(d);
        check((d == 0) ? "outs_fwd0" : "outs_fwd1", 32'(obs[d]), 32'(exp_o[d]));
      end
`ifdef HAZARD_STALL_STATS_EN
      check("stall_cnt0", 32'(bus0.stallCount), 32'(stc[0]));
      check("squash_cnt0", 32'(bus0.squashCount), 32'(sqc[0]));
      check("stall_cnt1", 32'(bus1.stallCount), 32'(stc[1]));
      check("squash_cnt1", 32'(bus1.squashCount), 32'(sqc[1]));
`endif
      if ($urandom_range(0, 99) == 0) begin
        // Asynchronous reset landing between clock edges.
        #1 rst = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        check_reset_outputs("rst_held");
        @(negedge clk);
        quiet_inputs();
        rst = 1'b1;
      end else begin
        @(posedge clk);
        model_commit();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
